// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM/op encodings and default widths for mem_responder (parity width follows MEM_PARITY_EN)
package mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;
    typedef enum logic {RD, WR} op_t;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;
`ifdef MEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU-side strobe/bus bundle between MAR/MDR and the memory responder
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              Read;
    logic              Write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;
    logic              overrun;
    logic              perr_inject;
    logic              perr;
    modport master (output Read, Write, addr, wdata, perr_inject,
                    input  rdata, ready, busy, err, overrun, perr);
    modport slave  (input  Read, Write, addr, wdata, perr_inject,
                    output rdata, ready, busy, err, overrun, perr);
endinterface

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM, registered read of the presented address every cycle
module mem_array #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);
    logic [DW-1:0] r_mem [2**AW];
    // write-first is irrelevant here: the responder never reads and writes in the same cycle
    always_ff @(posedge clk) begin
        if (we) r_mem[addr] <= din;
        dout <= r_mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: edge-triggered Read/Write responder with wait states over mem_array; MEM_PARITY_EN adds a parity bit per word
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_STATES = 0
) (
    input  logic           clk,
    input  logic           clr,
    mem_responder_if.slave bus
);
    localparam int         MW     = DATA_W + PAR_W;
    localparam logic [3:0] W_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    state_t            r_state, w_state_nx;
    op_t               r_op;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic [3:0]        r_cnt;
    logic              r_rd_q, r_wr_q, r_err, r_overrun;
    logic              w_req, w_both, w_accept, w_we;
    logic [MW-1:0]     w_din, w_dout;

    assign w_req    = (bus.Read & ~r_rd_q) | (bus.Write & ~r_wr_q);
    assign w_both   = bus.Read & bus.Write;
    assign w_accept = r_state == IDLE && w_req && !w_both;
    assign w_we     = clr && r_state == ACCESS && r_op == WR;
    // present the live address while idle so the array read is ready by the ACCESS cycle
    assign w_addr   = r_state == IDLE ? bus.addr : r_addr;

    mem_array #(.AW(ADDR_W), .DW(MW)) u_array (
        .clk  (clk),
        .we   (w_we),
        .addr (w_addr),
        .din  (w_din),
        .dout (w_dout)
    );

    // next-state: optional WAIT stretch between acceptance and the single ACCESS cycle
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE:    w_state_nx = w_accept ? (WAIT_STATES > 0 ? WAIT : ACCESS) : IDLE;
            WAIT:    w_state_nx = r_cnt == 4'd0 ? ACCESS : WAIT;
            ACCESS:  w_state_nx = DONE;
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!clr) r_state <= IDLE;
        else      r_state <= w_state_nx;
    end

    // edge history, read data capture and error flags
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_rd_q    <= 1'b0;
            r_wr_q    <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_rd_q <= bus.Read;
            r_wr_q <= bus.Write;
            r_err  <= r_state == IDLE && w_req && w_both;
            if (r_state != IDLE && w_req) r_overrun <= 1'b1;
            if (r_state == ACCESS && r_op == RD) r_rdata <= w_dout[DATA_W-1:0];
        end
    end

    // request latch and wait countdown; contents are don't-care outside an operation
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_op    <= bus.Read ? RD : WR;
            r_cnt   <= W_LOAD;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

`ifdef MEM_PARITY_EN
    logic r_par, r_perr;
    assign w_din    = {r_par, r_wdata};
    assign bus.perr = r_perr;
    // even parity stored with the word; a read flags when the whole stored word has odd weight
    always_ff @(posedge clk) begin
        if (w_accept) r_par <= ^bus.wdata ^ bus.perr_inject;
        if (!clr) r_perr <= 1'b0;
        else      r_perr <= r_state == ACCESS && r_op == RD && ^w_dout;
    end
`else
    assign w_din    = r_wdata;
    assign bus.perr = 1'b0;
`endif

    assign bus.rdata   = r_rdata;
    assign bus.ready   = r_state == DONE;
    assign bus.busy    = r_state != IDLE;
    assign bus.err     = r_err;
    assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three responders (0/2/3 wait states) driven in lockstep and checked against a transaction-level model
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        rd = 1'b0, wr = 1'b0, inj_s = 1'b0;
    logic [8:0]  addr_s = '0;
    logic [31:0] wd_s = '0;
    logic [2:0]  rdy, bsy, er, ovr, pe;
    logic [31:0] rdat [3];

`ifdef MEM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic [31:0] mdl [512];
    bit          known [512];
    bit          mbad [512];
    logic [31:0] last_rdata = '0;
    bit          ovr_exp = 1'b0;
    int          total = 0, bad = 0;
    int          wq[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : u
        mem_responder_if #(.ADDR_W(9), .DATA_W(32)) bus ();
        mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(g == 0 ? 0 : g + 1)) dut (
            .clk (clk),
            .clr (clr),
            .bus (bus)
        );
        assign bus.Read        = rd;
        assign bus.Write       = wr;
        assign bus.addr        = addr_s;
        assign bus.wdata       = wd_s;
        assign bus.perr_inject = inj_s;
        assign rdy[g]  = bus.ready;
        assign bsy[g]  = bus.busy;
        assign er[g]   = bus.err;
        assign ovr[g]  = bus.overrun;
        assign pe[g]   = bus.perr;
        assign rdat[g] = bus.rdata;
    end

    function automatic int ws(int i);
        return i == 0 ? 0 : i + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string nm);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({rdy[i], bsy[i], er[i], ovr[i], pe[i]} !== 5'b0 || rdat[i] !== 32'h0) begin
                bad++;
                $display("FAIL %s dut%0d: rdy/bsy/err/ovr/perr=%b rdata=%h want all 0", nm, i,
                         {rdy[i], bsy[i], er[i], ovr[i], pe[i]}, rdat[i]);
            end
        end
    endtask

    task automatic do_req(input bit w, input logic [8:0] a, input logic [31:0] dv, input bit inj, input string nm);
        int          rc[3], bc[3], rcyc[3];
        logic [31:0] rd_at[3];
        logic        pe_at[3];
        logic [31:0] exp_d;
        bit          chk_d, exp_pe;
        exp_d  = w ? last_rdata : mdl[a];
        chk_d  = w || known[a];
        exp_pe = !w && PAR && mbad[a];
        for (int i = 0; i < 3; i++) begin rc[i] = 0; bc[i] = 0; rcyc[i] = -1; rd_at[i] = 'x; pe_at[i] = 1'bx; end
        addr_s = a; wd_s = dv; inj_s = inj;
        if (w) wr = 1'b1; else rd = 1'b1;
        tick();
        rd = 1'b0; wr = 1'b0;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (bsy[i]) bc[i]++;
                if (rdy[i]) begin rc[i]++; rcyc[i] = c; rd_at[i] = rdat[i]; pe_at[i] = pe[i]; end
            end
            tick();
        end
        if (w) begin mdl[a] = dv; known[a] = 1'b1; mbad[a] = inj; end
        else if (known[a]) last_rdata = mdl[a];
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rc[i] !== 1) begin bad++; $display("FAIL %s ready_count dut%0d: got %0d want 1", nm, i, rc[i]); end
            total++;
            if (rcyc[i] !== 1 + ws(i)) begin bad++; $display("FAIL %s ready_latency dut%0d: got %0d want %0d", nm, i, rcyc[i], 1 + ws(i)); end
            total++;
            if (bc[i] !== 2 + ws(i)) begin bad++; $display("FAIL %s busy_cycles dut%0d: got %0d want %0d", nm, i, bc[i], 2 + ws(i)); end
            if (chk_d) begin
                total++;
                if (rd_at[i] !== exp_d) begin bad++; $display("FAIL %s rdata dut%0d: got %h want %h", nm, i, rd_at[i], exp_d); end
                total++;
                if (pe_at[i] !== exp_pe) begin bad++; $display("FAIL %s perr dut%0d: got %b want %b", nm, i, pe_at[i], exp_pe); end
            end
            total++;
            if (ovr[i] !== ovr_exp) begin bad++; $display("FAIL %s overrun dut%0d: got %b want %b", nm, i, ovr[i], ovr_exp); end
        end
    endtask

    task automatic test_reset();
        clr = 1'b0; rd = 1'b0; wr = 1'b0;
        tick(); tick();
        check_quiet("reset");
        clr = 1'b1;
        last_rdata = '0; ovr_exp = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_req(1'b1, 9'h05, 32'hDEADBEEF, 1'b0, "basic_wr");
        do_req(1'b0, 9'h05, 32'h0, 1'b0, "basic_rd");
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            if (wq.size() == 0 || $urandom_range(0, 1) == 0) begin
                logic [8:0] a;
                a = 9'($urandom_range(0, 511));
                wq.push_back(int'(a));
                do_req(1'b1, a, $urandom, 1'($urandom_range(0, 1)), "rand_wr");
            end else begin
                do_req(1'b0, 9'(wq[$urandom_range(0, wq.size() - 1)]), 32'h0, 1'b0, "rand_rd");
            end
        end
    endtask

    task automatic test_err();
        int rc[3], bc[3];
        do_req(1'b1, 9'h33, 32'hA5A5_0033, 1'b0, "err_pre");
        for (int i = 0; i < 3; i++) begin rc[i] = 0; bc[i] = 0; end
        addr_s = 9'h33; wd_s = 32'h0BAD_0BAD;
        rd = 1'b1; wr = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (er[i] !== 1'b1) begin bad++; $display("FAIL err_pulse dut%0d: got %b want 1", i, er[i]); end
        end
        rd = 1'b0; wr = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (er[i] !== 1'b0) begin bad++; $display("FAIL err_width dut%0d: got %b want 0", i, er[i]); end
        end
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 3; i++) begin rc[i] += int'(rdy[i]); bc[i] += int'(bsy[i]); end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rc[i] !== 0 || bc[i] !== 0) begin bad++; $display("FAIL err_noaccess dut%0d: ready=%0d busy=%0d want 0 0", i, rc[i], bc[i]); end
        end
        do_req(1'b0, 9'h33, 32'h0, 1'b0, "err_readback");
    endtask

    task automatic test_abort();
        do_req(1'b1, 9'h10, 32'h0000_1111, 1'b0, "abort_pre");
        addr_s = 9'h10; wd_s = 32'h0000_1234;
        wr = 1'b1;
        tick();
        wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bsy[i] !== 1'b1) begin bad++; $display("FAIL abort_accept dut%0d: busy=%b want 1", i, bsy[i]); end
        end
        clr = 1'b0;
        tick();
        check_quiet("abort_reset");
        clr = 1'b1;
        last_rdata = '0; ovr_exp = 1'b0;
        tick(); tick();
        do_req(1'b0, 9'h10, 32'h0, 1'b0, "abort_readback");
    endtask

    task automatic test_overrun();
        int          rc[3], rcyc[3];
        logic [31:0] rd_at[3];
        logic [8:0]  a;
        a = 9'($urandom_range(0, 511));
        do_req(1'b1, a, $urandom, 1'b0, "ovr_pre");
        for (int i = 0; i < 3; i++) begin rc[i] = 0; rcyc[i] = -1; rd_at[i] = 'x; end
        addr_s = a; wd_s = ~mdl[a];
        rd = 1'b1;
        tick();
        wr = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c == 2) wr = 1'b0;
            if (c == 9) rd = 1'b0;
            for (int i = 0; i < 3; i++)
                if (rdy[i]) begin rc[i]++; rcyc[i] = c; rd_at[i] = rdat[i]; end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rc[i] !== 1 || rcyc[i] !== 1 + ws(i)) begin
                bad++;
                $display("FAIL ovr_ready dut%0d: count=%0d at=%0d want 1 at %0d", i, rc[i], rcyc[i], 1 + ws(i));
            end
            total++;
            if (rd_at[i] !== mdl[a]) begin bad++; $display("FAIL ovr_rdata dut%0d: got %h want %h", i, rd_at[i], mdl[a]); end
            total++;
            if (ovr[i] !== 1'b1) begin bad++; $display("FAIL ovr_flag dut%0d: got %b want 1", i, ovr[i]); end
        end
        last_rdata = mdl[a];
        ovr_exp = 1'b1;
        do_req(1'b0, a, 32'h0, 1'b0, "ovr_readback");
    endtask

    task automatic test_parity();
        do_req(1'b1, 9'h20, 32'h0000_0001, 1'b1, "par_wr_inj");
        do_req(1'b0, 9'h20, 32'h0, 1'b0, "par_rd_inj");
        do_req(1'b1, 9'h21, 32'h0000_0003, 1'b0, "par_wr_clean");
        do_req(1'b0, 9'h21, 32'h0, 1'b0, "par_rd_clean");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_err();
        test_abort();
        test_parity();
        test_overrun();
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
